// File: rtl/alloc8_if.sv
// Handshake and status bundle for the eight-entry slot allocator.
// master = consumer/releaser side, slave = alloc8.
interface alloc8_if;
   logic       alloc_req;
   logic       alloc_ready;
   logic [2:0] alloc_idx;
   logic       free_valid;
   logic [2:0] free_idx;
   logic       flush;
   logic [7:0] valid_vec;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       err_bad_free;

   modport master (
      output alloc_req, free_valid, free_idx, flush,
      input  alloc_ready, alloc_idx, valid_vec,
      input  full, empty, count, err_bad_free
   );

   modport slave (
      input  alloc_req, free_valid, free_idx, flush,
      output alloc_ready, alloc_idx, valid_vec,
      output full, empty, count, err_bad_free
   );
endinterface

// File: rtl/alloc8.sv
// Eight-entry lowest-free slot allocator with valid tracking and status.
// ALLOC8_FREE_BYPASS_EN: grant a slot freed in the same cycle while full.
module alloc8 (
   input  logic    clk,
   input  logic    rst,
   alloc8_if.slave bus
);
   logic [7:0] valid_q, valid_d;
   logic [3:0] count_q, count_d;
   logic       err_q, err_d;

   logic       full_w;
   logic       good_free;
   logic       bypass;
   logic       ready_w;
   logic       fire;
   logic [2:0] low_idx;
   logic [2:0] grant_idx;

   assign full_w    = &valid_q;
   assign good_free = bus.free_valid & valid_q[bus.free_idx];

`ifdef ALLOC8_FREE_BYPASS_EN
   assign bypass = full_w & good_free;
`else
   assign bypass = 1'b0;
`endif

   // Scan downward so the lowest free index wins.
   always_comb begin
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!valid_q[i]) low_idx = i[2:0];
      end
   end

   assign ready_w   = ~full_w | bypass;
   assign grant_idx = bypass ? bus.free_idx : low_idx;
   assign fire      = bus.alloc_req & ready_w;

   always_comb begin
      valid_d = valid_q;
      count_d = count_q;
      err_d   = err_q | (bus.free_valid & ~valid_q[bus.free_idx]);
      if (bus.flush) begin
         valid_d = 8'h00;
         count_d = 4'd0;
      end else begin
         // Clear before set so a bypassed slot stays held.
         if (good_free) valid_d[bus.free_idx] = 1'b0;
         if (fire)      valid_d[grant_idx]    = 1'b1;
         count_d = count_q + 4'(fire) - 4'(good_free);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 8'h00;
         count_q <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign bus.alloc_ready  = ready_w;
   assign bus.alloc_idx    = grant_idx;
   assign bus.valid_vec    = valid_q;
   assign bus.full         = full_w;
   assign bus.empty        = (valid_q == 8'h00);
   assign bus.count        = count_q;
   assign bus.err_bad_free = err_q;
endmodule

// File: tb/tb_alloc8.sv
// Self-checking bench for alloc8: directed scenarios plus random traffic
// checked against a slot-array reference model.
module tb_alloc8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   alloc8_if bus();

   alloc8 dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

`ifdef ALLOC8_FREE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int passed = 0;
   int total  = 0;

   bit mv[8];
   bit merr;

   function automatic bit m_full();
      int n = 0;
      foreach (mv[i]) n += int'(mv[i]);
      return n == 8;
   endfunction

   function automatic logic [7:0] m_vec();
      logic [7:0] v;
      foreach (mv[i]) v[i] = mv[i];
      return v;
   endfunction

   function automatic logic [3:0] m_cnt();
      int n = 0;
      foreach (mv[i]) n += int'(mv[i]);
      return 4'(n);
   endfunction

   function automatic void m_clear();
      foreach (mv[i]) mv[i] = 1'b0;
   endfunction

   function automatic void m_comb(output bit rdy, output logic [2:0] idx);
      bit good, byp, found;
      good = bus.free_valid && mv[bus.free_idx];
      byp  = BYP && m_full() && good;
      rdy  = !m_full() || byp;
      idx  = 3'd0;
      found = 1'b0;
      if (byp) idx = bus.free_idx;
      else
         for (int i = 0; i < 8; i++)
            if (!found && !mv[i]) begin
               idx = 3'(i);
               found = 1'b1;
            end
   endfunction

   task automatic cyc(input bit req, input bit fv,
                      input bit [2:0] fi, input bit fl);
      @(negedge clk);
      bus.alloc_req  = req;
      bus.free_valid = fv;
      bus.free_idx   = fi;
      bus.flush      = fl;
      #1;
   endtask

   task automatic tick();
      bit rdy, fv, good;
      logic [2:0] idx;
      bit [2:0] fi;
      m_comb(rdy, idx);
      fv = bus.free_valid;
      fi = bus.free_idx;
      good = fv && mv[fi];
      if (fv && !mv[fi]) merr = 1'b1;
      if (bus.flush) m_clear();
      else begin
         if (good) mv[fi] = 1'b0;
         if (bus.alloc_req && rdy) mv[idx] = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.alloc_req  = 1'b0;
      bus.free_valid = 1'b0;
      bus.free_idx   = 3'd0;
      bus.flush      = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (bus.valid_vec !== 8'h00)
         $display("FAIL reset_vec got %h exp 00", bus.valid_vec);
      else passed++;
      total++;
      if (bus.count !== 4'd0)
         $display("FAIL reset_count got %0d exp 0", bus.count);
      else passed++;
      total++;
      if (bus.err_bad_free !== 1'b0)
         $display("FAIL reset_err got %b exp 0", bus.err_bad_free);
      else passed++;
      total++;
      if ({bus.full, bus.empty, bus.alloc_ready} !== 3'b011)
         $display("FAIL reset_flags got %b exp 011",
                  {bus.full, bus.empty, bus.alloc_ready});
      else passed++;
      total++;
      if (bus.alloc_idx !== 3'd0)
         $display("FAIL reset_idx got %0d exp 0", bus.alloc_idx);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      m_clear();
      merr = 1'b0;
   endtask

   task automatic fill();
      cyc(0, 0, 0, 1); tick();
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 0, 0); tick();
      end
   endtask

   task automatic test_fill();
      cyc(0, 0, 0, 1); tick();
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 0, 0);
         total++;
         if (bus.alloc_idx !== 3'(i) || bus.alloc_ready !== 1'b1)
            $display("FAIL fill_grant got idx %0d rdy %b exp idx %0d rdy 1",
                     bus.alloc_idx, bus.alloc_ready, i);
         else passed++;
         tick();
         total++;
         if (bus.count !== 4'(i + 1))
            $display("FAIL fill_count got %0d exp %0d", bus.count, i + 1);
         else passed++;
      end
      total++;
      if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0)
         $display("FAIL fill_full got full %b rdy %b exp 1 0",
                  bus.full, bus.alloc_ready);
      else passed++;
   endtask

   task automatic test_free_realloc();
      fill();
      cyc(0, 1, 5, 0); tick();
      total++;
      if (bus.count !== 4'd7 || bus.valid_vec !== 8'hDF)
         $display("FAIL free5 got cnt %0d vec %h exp 7 df",
                  bus.count, bus.valid_vec);
      else passed++;
      cyc(1, 0, 0, 0);
      total++;
      if (bus.alloc_idx !== 3'd5 || bus.alloc_ready !== 1'b1)
         $display("FAIL regrant5 got idx %0d rdy %b exp 5 1",
                  bus.alloc_idx, bus.alloc_ready);
      else passed++;
      tick();
      total++;
      if (bus.count !== 4'd8)
         $display("FAIL regrant5_count got %0d exp 8", bus.count);
      else passed++;
   endtask

   task automatic test_same_cycle();
      cyc(0, 0, 0, 1); tick();
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 0); tick();
      end
      cyc(1, 1, 1, 0);
      total++;
      if (bus.alloc_idx !== 3'd4)
         $display("FAIL same_idx got %0d exp 4", bus.alloc_idx);
      else passed++;
      tick();
      total++;
      if (bus.valid_vec !== 8'h1D || bus.count !== 4'd4)
         $display("FAIL same_state got vec %h cnt %0d exp 1d 4",
                  bus.valid_vec, bus.count);
      else passed++;
   endtask

   task automatic test_bad_free();
      cyc(0, 0, 0, 1); tick();
      cyc(1, 0, 0, 0); tick();
      cyc(1, 0, 0, 0); tick();
      cyc(0, 1, 6, 0); tick();
      total++;
      if (bus.valid_vec !== 8'h03 || bus.err_bad_free !== 1'b1)
         $display("FAIL bad_free got vec %h err %b exp 03 1",
                  bus.valid_vec, bus.err_bad_free);
      else passed++;
      cyc(0, 0, 0, 1); tick();
      total++;
      if (bus.err_bad_free !== 1'b1 || bus.valid_vec !== 8'h00)
         $display("FAIL err_sticky got err %b vec %h exp 1 00",
                  bus.err_bad_free, bus.valid_vec);
      else passed++;
   endtask

   task automatic test_flush_prio();
      fill();
      for (int i = 0; i < 8; i += 2) begin
         cyc(0, 1, 3'(i), 0); tick();
      end
      total++;
      if (bus.valid_vec !== 8'hAA)
         $display("FAIL build_aa got %h exp aa", bus.valid_vec);
      else passed++;
      cyc(1, 1, 1, 1); tick();
      total++;
      if (bus.valid_vec !== 8'h00 || bus.empty !== 1'b1 || bus.count !== 4'd0)
         $display("FAIL flush_prio got vec %h empty %b cnt %0d exp 00 1 0",
                  bus.valid_vec, bus.empty, bus.count);
      else passed++;
   endtask

   task automatic test_async_rst();
      cyc(1, 0, 0, 0); tick();
      cyc(1, 0, 0, 0); tick();
      cyc(1, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      total++;
      if (bus.valid_vec !== 8'h00 || bus.count !== 4'd0 ||
          bus.err_bad_free !== 1'b0)
         $display("FAIL async_rst got vec %h cnt %0d err %b exp 00 0 0",
                  bus.valid_vec, bus.count, bus.err_bad_free);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (bus.valid_vec !== 8'h00)
         $display("FAIL rst_hold got %h exp 00", bus.valid_vec);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      bus.alloc_req = 1'b0;
      m_clear();
      merr = 1'b0;
   endtask

   task automatic test_bypass();
      bit rdy;
      logic [2:0] idx;
      fill();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) cyc(1, 1, 2, 0);
         else        cyc(1, 0, 0, 0);
         m_comb(rdy, idx);
         total++;
         if (bus.alloc_ready !== rdy || bus.alloc_idx !== idx)
            $display("FAIL bypass_comb%0d got rdy %b idx %0d exp %b %0d",
                     k, bus.alloc_ready, bus.alloc_idx, rdy, idx);
         else passed++;
         tick();
         total++;
         if (bus.valid_vec !== m_vec() || bus.count !== m_cnt())
            $display("FAIL bypass_state%0d got %h/%0d exp %h/%0d",
                     k, bus.valid_vec, bus.count, m_vec(), m_cnt());
         else passed++;
      end
      total++;
      if (bus.valid_vec !== 8'hFF)
         $display("FAIL bypass_end got %h exp ff", bus.valid_vec);
      else passed++;
   endtask

   task automatic test_random();
      bit rdy;
      logic [2:0] idx;
      int bad = 0;
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(99) < 60, $urandom_range(99) < 45,
             3'($urandom_range(7)), $urandom_range(99) < 4);
         m_comb(rdy, idx);
         total++;
         if (bus.alloc_ready !== rdy || bus.alloc_idx !== idx) begin
            if (bad++ < 10)
               $display("FAIL rand_comb@%0d got %b/%0d exp %b/%0d",
                        n, bus.alloc_ready, bus.alloc_idx, rdy, idx);
         end else passed++;
         tick();
         total++;
         if (bus.valid_vec !== m_vec() || bus.count !== m_cnt() ||
             bus.full !== m_full() || bus.empty !== (m_cnt() == 0) ||
             bus.err_bad_free !== merr) begin
            if (bad++ < 10)
               $display("FAIL rand_state@%0d got %h/%0d/%b exp %h/%0d/%b",
                        n, bus.valid_vec, bus.count, bus.err_bad_free,
                        m_vec(), m_cnt(), merr);
         end else passed++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.alloc_req  = 1'b0;
      bus.free_valid = 1'b0;
      bus.free_idx   = 3'd0;
      bus.flush      = 1'b0;
      test_reset();
      test_fill();
      test_free_realloc();
      test_same_cycle();
      test_bad_free();
      test_flush_prio();
      test_async_rst();
      test_bypass();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
